// File: rtl/mem_stage_unit.sv
// mem_stage_unit: pipeline memory stage with a single outstanding data-cache request.
//   clk, rst (async, active-low)
//   in_valid/in_ready, is_load/is_store, funct3, alu_out, rs2_out, rd : upstream EX interface
//   dmem_address/read/write/wmask/wdata, dmem_rdata/resp               : data-cache interface
//   out_valid, out_data, out_rd, out_misalign                          : writeback interface
module mem_stage_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   alu_out,
    input  logic [DATA_W-1:0]   rs2_out,
    input  logic [4:0]          rd,
    output logic [ADDR_W-1:0]   dmem_address,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic [DATA_W/8-1:0] dmem_wmask,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic                dmem_resp,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [4:0]          out_rd,
    output logic                out_misalign
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                read_q, read_d, write_q, write_d;
    logic [NB-1:0]       wmask_q, wmask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [OW-1:0]       off_q, off_d;
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          prd_q, prd_d;
    logic                ov_q, ov_d, om_q, om_d;
    logic [DATA_W-1:0]   od_q, od_d;
    logic [4:0]          ord_q, ord_d;

    logic                mem_op, legal, misalign, accept;
    logic [2:0]          size_m1, lsize_m1;
    logic [NB-1:0]       bmask;
    logic [DATA_W-1:0]   sdata, shifted, load_res;
    logic                msb, ext;

    // access size minus one, in bytes, from the low two funct3 bits
    function automatic logic [2:0] size_of(input logic [2:0] f);
        return f[1:0] == 2'b00 ? 3'd0 : f[1:0] == 2'b01 ? 3'd1 : f[1:0] == 2'b10 ? 3'd3 : 3'd7;
    endfunction

    assign in_ready     = state_q == IDLE;
    assign accept       = in_valid && in_ready;
    assign mem_op       = is_load || is_store;
    assign dmem_address = addr_q;
    assign dmem_read    = read_q;
    assign dmem_write   = write_q;
    assign dmem_wmask   = wmask_q;
    assign dmem_wdata   = wdata_q;
    assign out_valid    = ov_q;
    assign out_data     = od_q;
    assign out_rd       = ord_q;
    assign out_misalign = om_q;

    // request decode: legality, alignment, byte lanes and store data
    always_comb begin
        size_m1 = size_of(funct3);
        legal = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101} ||
                           (DATA_W == 64 && funct3 inside {3'b011, 3'b110}))
                        : (funct3 inside {3'b000, 3'b001, 3'b010} ||
                           (DATA_W == 64 && funct3 == 3'b011));
        misalign = !legal || (|(alu_out[2:0] & size_m1));
        bmask = '0;
        sdata = '0;
        for (int i = 0; i < NB; i++) begin
            bmask[i] = i <= int'(size_m1);
            sdata[i*8 +: 8] = bmask[i] ? rs2_out[i*8 +: 8] : 8'h00;
        end
    end

    // load alignment and extension; funct3[2] selects zero extension
    always_comb begin
        lsize_m1 = size_of(f3_q);
        shifted = dmem_rdata >> {off_q, 3'b000};
        msb = f3_q[1:0] == 2'b00 ? shifted[7] : f3_q[1:0] == 2'b01 ? shifted[15] :
              f3_q[1:0] == 2'b10 ? shifted[31] : shifted[DATA_W-1];
        ext = msb && !f3_q[2];
        load_res = '0;
        for (int i = 0; i < DATA_W; i++)
            load_res[i] = (i < (int'(lsize_m1) + 1) * 8) ? shifted[i] : ext;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && accept && mem_op && !misalign)
            state_d = BUSY;
        else if (state_q == BUSY && dmem_resp)
            state_d = IDLE;
    end

    always_comb begin
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        f3_d    = f3_q;
        prd_d   = prd_q;
        ov_d    = 1'b0;
        od_d    = od_q;
        ord_d   = ord_q;
        om_d    = om_q;
        if (accept && mem_op && !misalign) begin
            addr_d  = {alu_out[ADDR_W-1:OW], {OW{1'b0}}};
            read_d  = is_load;
            write_d = !is_load;
            wmask_d = is_load ? '0 : bmask << alu_out[OW-1:0];
            wdata_d = is_load ? '0 : sdata << {alu_out[OW-1:0], 3'b000};
            off_d   = alu_out[OW-1:0];
            f3_d    = funct3;
            prd_d   = rd;
        end else if (accept) begin
            ov_d  = 1'b1;
            od_d  = mem_op ? '0 : DATA_W'(alu_out);
            ord_d = rd;
            om_d  = mem_op;
        end else if (state_q == BUSY && dmem_resp) begin
            addr_d  = '0;
            read_d  = 1'b0;
            write_d = 1'b0;
            wmask_d = '0;
            wdata_d = '0;
            ov_d    = 1'b1;
            od_d    = read_q ? load_res : '0;
            ord_d   = prd_q;
            om_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            prd_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ord_q   <= '0;
            om_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            prd_q   <= prd_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ord_q   <= ord_d;
            om_q    <= om_d;
        end
    end
endmodule

// File: doc/mem_stage_unit.md
MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/cache word width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream (EX) holds an instruction.
REQ-006 SHALL have port in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 SHALL have ports is_load and is_store  input  1 each  memory operation type; both 0 means pass-through.
REQ-008 SHALL have port funct3  input  3  access size and sign.
REQ-009 SHALL have ports alu_out (input, ADDR_W, effective address or ALU result), rs2_out (input, DATA_W, store data) and rd (input, 5, destination register).
REQ-010 SHALL have ports dmem_address (output, ADDR_W), dmem_read and dmem_write (output, 1 each), dmem_wmask (output, DATA_W/8), dmem_wdata (output, DATA_W), dmem_rdata (input, DATA_W) and dmem_resp (input, 1).
REQ-011 SHALL have ports out_valid (output, 1), out_data (output, DATA_W, load result or ALU result), out_rd (output, 5) and out_misalign (output, 1).

Function
REQ-012 SHALL implement states IDLE and BUSY; in_ready SHALL be 1 exactly when in IDLE.
REQ-013 In IDLE, in_valid with neither is_load nor is_store SHALL produce, one cycle later, out_valid=1, out_data=zero-extended alu_out, out_rd=rd, out_misalign=0; state stays IDLE.
REQ-014 funct3 encodings: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; when DATA_W=64 also 011 LD/SD and 110 LWU.
REQ-015 An access SHALL be misaligned when its address is not a multiple of its size; any other funct3 value SHALL also count as misaligned.
REQ-016 An accepted misaligned load or store SHALL issue no cache request, SHALL stay in IDLE, and SHALL produce, one cycle later, out_valid=1, out_misalign=1, out_data=0, out_rd=rd.
REQ-017 An accepted aligned load or store SHALL register the request and enter BUSY on the next edge.
REQ-018 In BUSY, the stage SHALL hold dmem_read or dmem_write (never both) and keep dmem_address, dmem_wmask and dmem_wdata stable until dmem_resp=1.
REQ-019 dmem_address SHALL be alu_out with its low log2(DATA_W/8) bits cleared; off = those low bits.
REQ-020 dmem_wmask SHALL be a contiguous run of size bits shifted left by off; dmem_wdata SHALL be the low size bytes of rs2_out shifted left by off*8; both SHALL be 0 for loads.
REQ-021 Load result SHALL be dmem_rdata shifted right by off*8, truncated to the access size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to DATA_W.
REQ-022 On dmem_resp=1 in BUSY, the next edge SHALL drop the request, return to IDLE and assert out_valid for exactly one cycle; out_data SHALL be the load result, or 0 for a store.
REQ-023 out_valid SHALL be a single-cycle pulse per accepted instruction; out_data, out_rd and out_misalign SHALL hold their values until the next out_valid.
REQ-024 dmem_resp while in IDLE SHALL be ignored.
REQ-025 Because in_ready=0 in BUSY, upstream holds the next instruction; it SHALL be accepted in the same cycle that out_valid is asserted.
REQ-026 Total load/store latency SHALL be 2 cycles plus cache wait cycles; an immediate dmem_resp gives out_valid 2 cycles after acceptance.

Reset
REQ-027 rst=0 SHALL asynchronously force state to IDLE and set dmem_read, dmem_write, dmem_wmask, dmem_wdata, dmem_address, out_valid, out_data, out_rd and out_misalign to 0.
REQ-028 Reset during BUSY SHALL abandon the outstanding request; a dmem_resp arriving after reset release SHALL be ignored (REQ-024).

Verification
REQ-029 Load byte: DATA_W=32, LB at 0x1003, dmem_rdata=0x80FF_1234, resp after 3 cycles -> dmem_address=0x1000, out_data=0xFFFF_FF80, out_valid 5 cycles after acceptance.
REQ-030 Store half: SH at 0x2002, rs2_out=0xABCD_BEEF -> dmem_write=1, dmem_wmask=4'b1100, dmem_wdata=0xBEEF_0000 held until resp; then out_valid with out_data=0.
REQ-031 Misaligned access: LW at 0x1001 -> no dmem_read, out_misalign=1, out_data=0 one cycle later.
REQ-032 Back-to-back instructions: an ALU op (alu_out=0x55, rd=7) held during BUSY -> in_ready=0 until the load completes, then accepted; out_valid with out_rd=7 and out_data=0x55 follows the load's out_valid by exactly one cycle.
REQ-033 64-bit mode: DATA_W=64, LWU at 0x...C, dmem_rdata=0xF000_0001_0000_0000 -> out_data=0x0000_0000_F000_0001; a funct3=011 access with DATA_W=32 -> out_misalign=1.
REQ-034 Reset in BUSY: rst=0 while dmem_read=1 -> all outputs 0 immediately; a later dmem_resp -> no out_valid.
